// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response port and core-facing instruction port
interface fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
        input  mem_ready, mem_rvalid, mem_rdata, stall, redirect, redirect_pc
    );
    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
        output mem_ready, mem_rvalid, mem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with credit-limited requests,
// an in-order {pc, instr} response FIFO and redirect flush of stale responses
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h1000_0000,
    parameter int          DEPTH    = 4
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   fetch_pc, tag_pc, target;
    logic [CW-1:0] occ, outst, disc;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic          accept, rsp, push, pop, valid;

    assign target = bus.redirect_pc & ~32'd3;
    assign valid  = !rst && occ != '0;
    // a response with nothing outstanding is a protocol error and is ignored
    assign rsp    = bus.mem_rvalid && outst != '0;
    assign push   = rsp && disc == '0 && !bus.redirect;
    assign pop    = valid && !bus.stall && !bus.redirect;
    assign accept = bus.mem_req && bus.mem_ready;

    assign bus.mem_req        = !rst && !bus.redirect && (occ + outst < CW'(DEPTH));
    assign bus.mem_addr       = fetch_pc;
    assign bus.instr_valid    = valid;
    assign bus.instr          = valid ? data_mem[rd_ptr] : 32'h0000_0013;
    assign bus.instr_pc       = valid ? pc_mem[rd_ptr] : '0;
    assign bus.instr_pc_plus4 = valid ? pc_mem[rd_ptr] + 32'd4 : '0;

    // tag_pc tracks the address of the next response that will be kept
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            tag_pc   <= RESET_PC;
            occ      <= '0;
            outst    <= '0;
            disc     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= target;
            tag_pc   <= target;
            occ      <= '0;
            outst    <= outst - CW'(rsp);
            disc     <= outst - CW'(rsp);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            fetch_pc <= accept ? fetch_pc + 32'd4 : fetch_pc;
            tag_pc   <= push ? tag_pc + 32'd4 : tag_pc;
            occ      <= occ + CW'(push) - CW'(pop);
            outst    <= outst + CW'(accept) - CW'(rsp);
            disc     <= disc - CW'(rsp && disc != '0);
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.mem_rdata;
            pc_mem[wr_ptr]   <= tag_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench with an in-order variable-latency memory model
module tb_fetch_queue;
    localparam logic [31:0] RPC = 32'h1000_0000;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    fetch_queue_if bus();
    fetch_queue #(.RESET_PC(RPC), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t        pipe[$];
    logic [31:0] sb[$];
    logic [31:0] acc_log[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc, last_due, lat_lo, lat_hi, pops, req_cnt, first_acc_cyc, first_valid_cyc;
    logic [31:0] first_pop_pc;

    function automatic logic [31:0] word(input logic [31:0] a);
        return ~a ^ 32'h5a5a_0000;
    endfunction

    // one cycle: memory model drives response, bookkeeping on accepts/pops/redirects
    task automatic step();
        rsp_t        r;
        logic [31:0] e;
        int          d;
        bus.mem_rvalid = 0;
        bus.mem_rdata  = '0;
        if (pipe.size() != 0 && pipe[0].due <= cyc) begin
            r = pipe.pop_front();
            bus.mem_rvalid = 1;
            bus.mem_rdata  = word(r.addr);
        end
        #1;
        if (bus.mem_req) req_cnt++;
        if (bus.instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.mem_req && bus.mem_ready) begin
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            r.addr = bus.mem_addr;
            r.due  = d;
            pipe.push_back(r);
            sb.push_back(r.addr);
            acc_log.push_back(r.addr);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (bus.instr_valid && !bus.stall && !bus.redirect) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h, expected no valid entry", bus.instr_pc, bus.instr);
            end else begin
                e = sb.pop_front();
                if (bus.instr_pc !== e || bus.instr !== word(e) || bus.instr_pc_plus4 !== e + 32'd4) begin
                    n_fail++;
                    $display("FAIL pop_order: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                             bus.instr_pc, bus.instr, bus.instr_pc_plus4, e, word(e), e + 32'd4);
                end
            end
            if (pops == 0) first_pop_pc = bus.instr_pc;
            pops++;
        end
        if (bus.redirect) sb.delete();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int lo, input int hi);
        rst = 1;
        bus.mem_ready = 1; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
        bus.mem_rvalid = 0; bus.mem_rdata = '0;
        pipe.delete(); sb.delete(); acc_log.delete();
        lat_lo = lo; lat_hi = hi; last_due = -1; pops = 0; req_cnt = 0;
        first_acc_cyc = -1; first_valid_cyc = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        bus.mem_ready = 1; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
        bus.mem_rvalid = 0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_chk += 5;
        if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, expected 0", bus.mem_req); end
        if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", bus.instr_valid); end
        if (bus.instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h, expected 00000013", bus.instr); end
        if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h, expected 0", bus.instr_pc); end
        if (bus.instr_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h, expected 0", bus.instr_pc_plus4); end
    endtask

    task automatic test_sequential();
        do_reset(1, 1);
        repeat (12) step();
        n_chk += 5;
        if (acc_log[0] !== RPC) begin n_fail++; $display("FAIL seq_addr0: got %h, expected %h", acc_log[0], RPC); end
        if (acc_log[1] !== RPC + 32'd4) begin n_fail++; $display("FAIL seq_addr1: got %h, expected %h", acc_log[1], RPC + 32'd4); end
        if (acc_log[2] !== RPC + 32'd8) begin n_fail++; $display("FAIL seq_addr2: got %h, expected %h", acc_log[2], RPC + 32'd8); end
        if (first_valid_cyc - first_acc_cyc != 2) begin
            n_fail++; $display("FAIL seq_latency: got %0d, expected 2", first_valid_cyc - first_acc_cyc);
        end
        if (first_pop_pc !== RPC) begin n_fail++; $display("FAIL seq_first_pc: got %h, expected %h", first_pop_pc, RPC); end
    endtask

    task automatic test_stall_full();
        do_reset(1, 1);
        bus.stall = 1;
        repeat (10) step();
        n_chk += 3;
        if (acc_log.size() != 4) begin n_fail++; $display("FAIL stall_accepts: got %0d, expected 4", acc_log.size()); end
        if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b, expected 0", bus.mem_req); end
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== RPC) begin
            n_fail++; $display("FAIL stall_head: got valid=%b pc=%h, expected valid=1 pc=%h", bus.instr_valid, bus.instr_pc, RPC);
        end
        bus.stall = 0;
        pops = 0;
        req_cnt = 0;
        repeat (8) step();
        n_chk += 3;
        if (pops < 4) begin n_fail++; $display("FAIL stall_pops: got %0d, expected >=4", pops); end
        if (req_cnt == 0) begin n_fail++; $display("FAIL stall_req_resume: got %0d, expected >0", req_cnt); end
        if (acc_log[4] !== RPC + 32'd16) begin n_fail++; $display("FAIL stall_next_addr: got %h, expected %h", acc_log[4], RPC + 32'd16); end
    endtask

    task automatic test_redirect();
        do_reset(5, 5);
        repeat (3) step();
        bus.redirect = 1;
        bus.redirect_pc = 32'h1000_0102;
        #1;
        n_chk += 2;
        if (acc_log.size() != 3) begin n_fail++; $display("FAIL redir_outstanding: got %0d, expected 3", acc_log.size()); end
        if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b, expected 0", bus.mem_req); end
        step();
        bus.redirect = 0;
        acc_log.delete();
        pops = 0;
        repeat (15) step();
        n_chk += 3;
        if (acc_log[0] !== 32'h1000_0100) begin n_fail++; $display("FAIL redir_addr: got %h, expected 10000100", acc_log[0]); end
        if (pops == 0) begin n_fail++; $display("FAIL redir_no_pop: got 0 pops, expected >0"); end
        if (first_pop_pc !== 32'h1000_0100) begin n_fail++; $display("FAIL redir_first_pc: got %h, expected 10000100", first_pop_pc); end
    endtask

    task automatic test_redirect_rvalid();
        do_reset(2, 2);
        repeat (2) step();
        bus.redirect = 1;
        bus.redirect_pc = 32'h0000_4000;
        step();
        bus.redirect = 0;
        pops = 0;
        repeat (10) step();
        n_chk += 2;
        if (pops == 0) begin n_fail++; $display("FAIL rv_no_pop: got 0 pops, expected >0"); end
        if (first_pop_pc !== 32'h0000_4000) begin n_fail++; $display("FAIL rv_first_pc: got %h, expected 00004000", first_pop_pc); end
    endtask

    task automatic test_ready_low();
        do_reset(1, 1);
        bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk += 2;
            if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rdy_req%0d: got %b, expected 1", i, bus.mem_req); end
            if (bus.mem_addr !== RPC) begin n_fail++; $display("FAIL rdy_addr%0d: got %h, expected %h", i, bus.mem_addr, RPC); end
            step();
        end
        bus.mem_ready = 1;
        step();
        n_chk += 2;
        if (acc_log.size() != 1 || acc_log[0] !== RPC) begin
            n_fail++; $display("FAIL rdy_accept: got n=%0d addr=%h, expected n=1 addr=%h", acc_log.size(), acc_log[0], RPC);
        end
        if (bus.mem_addr !== RPC + 32'd4) begin n_fail++; $display("FAIL rdy_advance: got %h, expected %h", bus.mem_addr, RPC + 32'd4); end
    endtask

    task automatic test_back_to_back();
        do_reset(3, 3);
        repeat (4) step();
        acc_log.delete();
        bus.redirect = 1;
        bus.redirect_pc = 32'h0000_2000;
        step();
        bus.redirect_pc = 32'h0000_3000;
        step();
        bus.redirect = 0;
        pops = 0;
        repeat (20) step();
        n_chk += 2;
        if (acc_log[0] !== 32'h0000_3000) begin n_fail++; $display("FAIL b2b_addr: got %h, expected 00003000", acc_log[0]); end
        if (pops == 0 || first_pop_pc !== 32'h0000_3000) begin
            n_fail++; $display("FAIL b2b_first_pc: got pops=%0d pc=%h, expected pc=00003000", pops, first_pop_pc);
        end
    endtask

    task automatic test_random();
        do_reset(1, 4);
        for (int i = 0; i < 300; i++) begin
            bus.mem_ready   = $urandom_range(3, 0) != 0;
            bus.stall       = $urandom_range(3, 0) == 0;
            bus.redirect    = $urandom_range(19, 0) == 0;
            bus.redirect_pc = $urandom;
            step();
        end
        bus.mem_ready = 1; bus.stall = 0; bus.redirect = 0;
        repeat (30) step();
        n_chk++;
        if (pops == 0) begin n_fail++; $display("FAIL rand_no_pop: got 0 pops, expected >0"); end
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk += 2;
        if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b, expected 0", bus.instr_valid); end
        if (bus.mem_addr !== RPC) begin n_fail++; $display("FAIL midreset_addr: got %h, expected %h", bus.mem_addr, RPC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_full();
        test_redirect();
        test_redirect_rvalid();
        test_ready_low();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
